// File: rtl/midi_message_assembler.sv
// midi_message_assembler
// Assembles a received MIDI byte stream into complete channel messages.
// Handles running status, real-time bytes interleaved anywhere, SysEx
// skipping, and channel/type filtering. Each accepted message is presented
// with a one-cycle valid_out pulse on the cycle after its final byte.
module midi_message_assembler #(
  parameter bit         OMNI     = 1'b1,  // 1: accept every channel
  parameter logic [3:0] CHANNEL  = 4'd0,  // channel accepted when OMNI=0
  parameter bit         PASS_ALL = 1'b0   // 0: only Note Off / Note On
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic [3:0] status,
  output logic [3:0] channel,
  output logic [7:0] data_byte1,
  output logic [7:0] data_byte2,
  output logic       valid_out,
  output logic       msg_error
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2,
    S_SYSEX   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_run_status;
  logic [6:0] r_d1;
  logic [3:0] r_status;
  logic [3:0] r_channel;
  logic [6:0] r_data1;
  logic [6:0] r_data2;
  logic       r_valid;
  logic       r_error;

  // Byte classification. Real-time bytes are invisible to everything else.
  logic w_byte;
  logic w_is_rt;
  logic w_is_data;
  logic w_is_chan_status;
  logic w_is_sysex_start;
  logic w_is_sys_common;

  assign w_byte           = byte_valid_in && !w_is_rt;
  assign w_is_rt          = &byte_in[7:3];
  assign w_is_data        = !byte_in[7];
  assign w_is_chan_status = byte_in[7] && (byte_in[7:4] != 4'hF);
  assign w_is_sysex_start = (byte_in == 8'hF0);
  assign w_is_sys_common  = (byte_in[7:4] == 4'hF) && !byte_in[3];

  // Program Change (0xC) and Channel Pressure (0xD) carry a single data byte.
  logic w_two_byte;
  assign w_two_byte = (r_run_status[7:4] == 4'hC) || (r_run_status[7:4] == 4'hD);

  // Filter applied at completion; dropped messages still advance running status.
  logic w_pass;
  assign w_pass = (OMNI || (r_run_status[3:0] == CHANNEL)) &&
                  (PASS_ALL || (r_run_status[7:4] == 4'h8) || (r_run_status[7:4] == 4'h9));

  logic w_d1_load;
  logic w_complete;
  logic w_stray;
  logic w_emit;

  assign w_emit = w_complete && w_pass;

  // Completing byte is the first data byte for 2-byte types, the second otherwise.
  logic [6:0] w_msg_d1;
  logic [6:0] w_msg_d2;
  assign w_msg_d1 = (r_state == S_WAIT_D1) ? byte_in[6:0] : r_d1;
  assign w_msg_d2 = (r_state == S_WAIT_D1) ? 7'd0 : byte_in[6:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-byte decisions.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_d1_load   = 1'b0;
    w_complete  = 1'b0;
    w_stray     = 1'b0;
    if (w_byte) begin
      if (w_is_chan_status) begin
        w_state_nxt = S_WAIT_D1;
      end else if (w_is_sysex_start) begin
        w_state_nxt = S_SYSEX;
      end else if (w_is_sys_common) begin
        w_state_nxt = S_IDLE;
      end else if (w_is_data) begin
        case (r_state)
          S_IDLE:    w_stray = 1'b1;
          S_WAIT_D1: begin
            w_d1_load = 1'b1;
            if (w_two_byte) w_complete = 1'b1;
            else            w_state_nxt = S_WAIT_D2;
          end
          S_WAIT_D2: begin
            w_complete  = 1'b1;
            w_state_nxt = S_WAIT_D1;
          end
          default: ;  // SysEx payload is discarded
        endcase
      end
    end
  end

  // Running status and first-data-byte holding registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_run_status <= 8'h00;
      r_d1         <= 7'd0;
    end else begin
      if (w_byte && w_is_chan_status)                         r_run_status <= byte_in;
      else if (w_byte && (w_is_sysex_start || w_is_sys_common)) r_run_status <= 8'h00;
      if (w_d1_load) r_d1 <= byte_in[6:0];
    end
  end

  // Output registers: fields hold between pulses, strobes last one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_status  <= 4'd0;
      r_channel <= 4'd0;
      r_data1   <= 7'd0;
      r_data2   <= 7'd0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_error <= w_stray;
      if (w_emit) begin
        r_status  <= r_run_status[7:4];
        r_channel <= r_run_status[3:0];
        r_data1   <= w_msg_d1;
        r_data2   <= w_msg_d2;
      end
    end
  end

  assign status     = r_status;
  assign channel    = r_channel;
  assign data_byte1 = {1'b0, r_data1};
  assign data_byte2 = {1'b0, r_data2};
  assign valid_out  = r_valid;
  assign msg_error  = r_error;

endmodule

// File: tb/tb_midi_message_assembler.sv
// Testbench for midi_message_assembler: two instances (omni/notes-only and
// channel-2/pass-all) share one byte stream and are compared every cycle
// against a message-level reference model.
module tb_midi_message_assembler;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid_in = 1'b0;

  logic [3:0] st0, ch0, st1, ch1;
  logic [7:0] d10, d20, d11, d21;
  logic       v0, e0, v1, e1;

  midi_message_assembler u_omni (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .status(st0), .channel(ch0), .data_byte1(d10), .data_byte2(d20),
    .valid_out(v0), .msg_error(e0)
  );

  midi_message_assembler #(.OMNI(1'b0), .CHANNEL(4'd2), .PASS_ALL(1'b1)) u_filt (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .status(st1), .channel(ch1), .data_byte1(d11), .data_byte2(d21),
    .valid_out(v1), .msg_error(e1)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (message level) ----------------
  bit         p_omni [2] = '{1'b1, 1'b0};
  logic [3:0] p_chan [2] = '{4'd0, 4'd2};
  bit         p_all  [2] = '{1'b0, 1'b1};

  int         m_rs   [2];          // running status byte, -1 when none
  bit         m_sx   [2];          // inside SysEx
  logic [7:0] m_data [2][$];       // data bytes collected for current message
  logic [3:0] m_st [2], m_ch [2];
  logic [7:0] m_d1 [2], m_d2 [2];
  logic       m_v [2], m_e [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rs[i] = -1; m_sx[i] = 1'b0; m_data[i].delete();
      m_st[i] = 0; m_ch[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_v[i] = 0; m_e[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0;
      m_e[i] = 1'b0;
      if (!v || b >= 8'hF8) continue;
      if (b >= 8'hF0) begin
        m_rs[i] = -1; m_sx[i] = (b == 8'hF0); m_data[i].delete();
      end else if (b >= 8'h80) begin
        m_rs[i] = int'(b); m_sx[i] = 1'b0; m_data[i].delete();
      end else if (m_sx[i]) begin
        // SysEx payload
      end else if (m_rs[i] < 0) begin
        m_e[i] = 1'b1;
      end else begin
        int typ, chn, need;
        typ  = m_rs[i] / 16;
        chn  = m_rs[i] % 16;
        need = (typ == 12 || typ == 13) ? 1 : 2;
        m_data[i].push_back(b);
        if (m_data[i].size() == need) begin
          if ((p_omni[i] || chn == int'(p_chan[i])) && (p_all[i] || typ == 8 || typ == 9)) begin
            m_v[i]  = 1'b1;
            m_st[i] = typ[3:0];
            m_ch[i] = chn[3:0];
            m_d1[i] = m_data[i][0];
            m_d2[i] = (need == 2) ? m_data[i][1] : 8'h00;
          end
          m_data[i].delete();
        end
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_omni"}, {6'd0, st0, ch0, d10, d20, v0, e0},
          {6'd0, m_st[0], m_ch[0], m_d1[0], m_d2[0], m_v[0], m_e[0]});
    check({tag, "_filt"}, {6'd0, st1, ch1, d11, d21, v1, e1},
          {6'd0, m_st[1], m_ch[1], m_d1[1], m_d2[1], m_v[1], m_e[1]});
  endtask

  // Present one cycle of input (called at posedge+1), then check after the edge.
  task automatic cycle(input logic v, input logic [7:0] b, input string tag);
    byte_valid_in = v;
    byte_in       = b;
    model_step(v, b);
    @(posedge clk_in);
    #1;
    byte_valid_in = 1'b0;
    compare_all(tag);
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    cycle(1'b1, b, tag);
  endtask

  task automatic apply_reset(input string tag);
    rst_in = 1'b1;
    #1;
    model_reset();
    compare_all({tag, "_in_reset"});
    @(posedge clk_in);
    #1;
    compare_all({tag, "_held_reset"});
    rst_in = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    compare_all("por");
    rst_in = 1'b0;

    // 1. basic Note On
    send(8'h90, "t1"); send(8'h3C, "t1"); send(8'h64, "t1");
    check("t1_msg", {6'd0, st0, ch0, d10, d20, v0, e0}, {6'd0, 4'h9, 4'h0, 8'h3C, 8'h64, 1'b1, 1'b0});
    cycle(1'b0, 8'h00, "t1_idle");
    check("t1_one_pulse", {31'd0, v0}, 32'd0);

    // 2. running status
    send(8'h91, "t2"); send(8'h40, "t2"); send(8'h7F, "t2");
    check("t2_msg_a", {6'd0, st0, ch0, d10, d20, v0, e0}, {6'd0, 4'h9, 4'h1, 8'h40, 8'h7F, 1'b1, 1'b0});
    send(8'h43, "t2"); send(8'h00, "t2");
    check("t2_msg_b", {6'd0, st0, ch0, d10, d20, v0, e0}, {6'd0, 4'h9, 4'h1, 8'h43, 8'h00, 1'b1, 1'b0});

    // 3. real-time interleave
    send(8'h80, "t3"); send(8'hF8, "t3"); send(8'h3C, "t3"); send(8'hFE, "t3"); send(8'h40, "t3");
    check("t3_msg", {6'd0, st0, ch0, d10, d20, v0, e0}, {6'd0, 4'h8, 4'h0, 8'h3C, 8'h40, 1'b1, 1'b0});

    // 4. SysEx skip, then stray data
    send(8'hF0, "t4"); send(8'h7E, "t4"); send(8'h01, "t4"); send(8'hF7, "t4"); send(8'h45, "t4");
    check("t4_err", {30'd0, v0, e0}, {30'd0, 1'b0, 1'b1});

    // 5. channel / type filter
    send(8'h93, "t5"); send(8'h3C, "t5"); send(8'h64, "t5");
    check("t5_ch3_drop", {31'd0, v1}, 32'd0);
    send(8'h92, "t5"); send(8'h3C, "t5"); send(8'h64, "t5");
    check("t5_ch2_pass", {31'd0, v1}, 32'd1);
    send(8'hC2, "t5"); send(8'h05, "t5");
    check("t5_pc_drop_notes_only", {31'd0, v0}, 32'd0);
    check("t5_pc_pass_all", {6'd0, st1, ch1, d11, d21, v1, e1}, {6'd0, 4'hC, 4'h2, 8'h05, 8'h00, 1'b1, 1'b0});

    // 6. reset mid-message
    send(8'h90, "t6"); send(8'h3C, "t6");
    apply_reset("t6");
    send(8'h64, "t6");
    check("t6_err_after_reset", {30'd0, v0, e0}, {30'd0, 1'b0, 1'b1});

    // Randomized stream
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] b;
      logic       v;
      r = $urandom_range(0, 999);
      v = 1'b1;
      if (r < 4) begin
        apply_reset("rnd");
        continue;
      end else if (r < 500) b = 8'($urandom_range(0, 127));
      else if (r < 700) begin
        b[7:4] = 4'($urandom_range(8, 14));
        b[3:0] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      end
      else if (r < 780) b = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 820) b = 8'hF0;
      else if (r < 860) b = 8'($urandom_range(8'hF1, 8'hF7));
      else begin
        v = 1'b0;
        b = 8'($urandom_range(0, 255));
      end
      cycle(v, b, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
